fpu_fp16_to_int: RTL and testbench
==================================

Name: fpu_fp16_to_int

Overview:
- Multi-cycle converter from an FP16 value (fp16_t) to a signed two's-complement integer. Rounds toward zero.
- This is the decode direction of the FP16 datapath: it unpacks sign/exp/frac, restores the hidden bit and de-normalizes the significand with an iterative 1-bit/cycle shifter.
- Sits behind the FPU operand bus with valid/ready handshakes on both sides. It reports invalid (NaN/Inf/overflow) and inexact flags.

Parameters:
- INT_W, 16, output integer width; legal range 16..32.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  converter can accept an operand.
- in_fp  input  16  FP16 operand: sign[15], exp[14:10], frac[9:0].
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_int  output  INT_W  signed integer result.
- out_invalid  output  1  NaN, Inf or out-of-range input; result saturated.
- out_inexact  output  1  nonzero bits discarded by truncation.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, out_int=0, out_invalid=0, out_inexact=0. Internal sig/cnt/sticky are cleared.
- Reset mid-operation: the in-flight transaction is dropped with no output. in_ready=1 on the cycle after reset deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_fp, go to SHIFT.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE.
  - The next operand is accepted no earlier than the cycle after the output handshake; there is no input/output overlap.
- Setup at accept, with sig = {exp!=0, frac} in an 11-bit working register widened for left shift:
  - exp==31 (Inf/NaN): cnt=0, special=1.
  - exp==0 (zero/denormal): cnt=0, result magnitude 0, inexact = (frac!=0).
  - exp<=14 (normal, |x|<1): cnt=0, magnitude 0, inexact=1.
  - 15<=exp<=24: right shift, cnt = 25-exp (1..10).
  - exp==25: cnt=0, no shift.
  - exp>=26: left shift, cnt = exp-25 (1..5).
- SHIFT:
  - With cnt!=0, each edge shifts sig 1 bit in the selected direction and decrements cnt.
  - On a right shift, the shifted-out bit ORs into sticky.
  - When cnt==0, the final result is registered and the state moves to DONE.
- Final result:
  - mag = sig. The overflow limit is 2^(INT_W-1)-1 for positive values and 2^(INT_W-1) for negative values.
  - special, or mag > limit: out_int = sign ? most-negative : most-positive, out_invalid=1, out_inexact=0.
  - NaN of either sign returns most-positive.
  - Otherwise: out_int = sign ? -mag : mag, out_invalid=0, out_inexact=sticky (or the setup-time inexact). -0.0 yields 0.
- Latency: in_valid-accept cycle to out_valid = cnt+2 cycles. The range is 2 (cnt=0) to 12 (exp=15).
- Widths: the working register is 16 bits (max 2047<<5 = 65504). Comparisons and negation are done in INT_W+1 bits so that the most-negative value is exact.

Test Plan:
- 1.0, in_fp=0x3C00 -> out_int=1, invalid=0, inexact=0. out_valid exactly 12 cycles after accept.
- -2.5, in_fp=0xC100 -> out_int=0xFFFE (-2), inexact=1, invalid=0. Latency 11.
- Boundaries:
  - in_fp=0xF800 (-32768) -> out_int=0x8000, invalid=0, inexact=0.
  - in_fp=0x7800 (+32768) -> 0x7FFF, invalid=1.
  - in_fp=0x7BFF (65504) -> 0x7FFF, invalid=1.
- Specials:
  - 0x7C00 -> 0x7FFF, invalid=1.
  - 0xFC00 -> 0x8000, invalid=1.
  - 0x7E00 -> 0x7FFF, invalid=1.
  - 0x0001 -> 0, inexact=1.
  - 0x8000 -> 0, flags 0.
  - 0x3800 (0.5) -> 0, inexact=1. Each has latency 2.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid on input 0x4500 (5.0) -> out_int=5 stable, in_ready=0 throughout. Then raise out_ready -> out_valid=0 and in_ready=1 the next cycle. A back-to-back second operand 0x4900 (10.0) -> 10.
- Reset mid-SHIFT: accept 0x3C00, assert reset at cycle 4 -> out_valid never rises, in_ready=1 after reset deasserts. A subsequent 0x4000 -> 2.

Source files
------------

// File: rtl/fpu_fp16_to_int.sv
// ---------------------------------------------------------------------------
// FpuFp16ToInt : FP16 -> signed integer converter, round toward zero.
//
// Unpacks an FP16 operand, restores the hidden bit and de-normalizes the
// significand with a 1-bit-per-cycle shifter, then saturates or negates the
// magnitude into an INT_W-bit two's-complement result.
//
// Ports:
//   clock        sole clock, all state changes on posedge
//   reset        synchronous, active-high
//   in_valid     operand valid           in_ready    converter idle
//   in_fp        FP16 operand {sign, exp[4:0], frac[9:0]}
//   out_valid    result valid            out_ready   consumer accepts result
//   out_int      signed INT_W-bit result (held stable while out_valid)
//   out_invalid  NaN, Inf or out-of-range input; result saturated
//   out_inexact  nonzero bits were discarded by truncation
// ---------------------------------------------------------------------------
module fpu_fp16_to_int #(
    parameter int INT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_fp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [INT_W-1:0] out_int,
    output logic             out_invalid,
    output logic             out_inexact
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Saturation limits are kept one bit wider than the result so that the
    // negative limit 2^(INT_W-1) is representable as a plain magnitude.
    localparam logic [INT_W:0]   LIM_POS  = {2'b00, {(INT_W-1){1'b1}}};
    localparam logic [INT_W:0]   LIM_NEG  = {2'b01, {(INT_W-1){1'b0}}};
    localparam logic [INT_W-1:0] MOST_POS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] MOST_NEG = {1'b1, {(INT_W-1){1'b0}}};

    state_t             stateQ, stateD;
    logic [15:0]        sigQ, sigD;
    logic [3:0]         cntQ, cntD;
    logic               leftQ, leftD;
    logic               stickyQ, stickyD;
    logic               signQ, signD;
    logic               specialQ, specialD;
    logic               nanQ, nanD;
    logic [INT_W-1:0]   outIntQ, outIntD;
    logic               outInvalidQ, outInvalidD;
    logic               outInexactQ, outInexactD;

    logic [4:0]         expIn;
    logic [9:0]         fracIn;
    logic [INT_W:0]     magExt;
    logic [INT_W:0]     negMag;
    logic [INT_W:0]     limit;

    assign expIn  = in_fp[14:10];
    assign fracIn = in_fp[9:0];
    assign magExt = {{(INT_W-15){1'b0}}, sigQ};
    assign negMag = -magExt;
    assign limit  = signQ ? LIM_NEG : LIM_POS;

    assign in_ready    = (stateQ == IDLE);
    assign out_valid   = (stateQ == DONE);
    assign out_int     = outIntQ;
    assign out_invalid = outInvalidQ;
    assign out_inexact = outInexactQ;

    // Next-state logic: operand setup on accept, one shift step per cycle in
    // SHIFT, result formation when the shift count runs out, and output hold
    // in DONE until the consumer takes the result.
    always_comb begin
        stateD      = stateQ;
        sigD        = sigQ;
        cntD        = cntQ;
        leftD       = leftQ;
        stickyD     = stickyQ;
        signD       = signQ;
        specialD    = specialQ;
        nanD        = nanQ;
        outIntD     = outIntQ;
        outInvalidD = outInvalidQ;
        outInexactD = outInexactQ;

        case (stateQ)
            IDLE: begin
                if (in_valid) begin
                    stateD   = SHIFT;
                    signD    = in_fp[15];
                    specialD = 1'b0;
                    nanD     = 1'b0;
                    stickyD  = 1'b0;
                    leftD    = 1'b0;
                    cntD     = 4'd0;
                    sigD     = 16'd0;
                    if (expIn == 5'd31) begin
                        specialD = 1'b1;
                        nanD     = (fracIn != 10'd0);
                    end else if (expIn == 5'd0) begin
                        stickyD = (fracIn != 10'd0);
                    end else if (expIn <= 5'd14) begin
                        // |x| < 1 truncates to zero but always loses bits.
                        stickyD = 1'b1;
                    end else if (expIn <= 5'd24) begin
                        sigD = {5'd0, 1'b1, fracIn};
                        cntD = 4'(5'd25 - expIn);
                    end else if (expIn == 5'd25) begin
                        sigD = {5'd0, 1'b1, fracIn};
                    end else begin
                        sigD  = {5'd0, 1'b1, fracIn};
                        leftD = 1'b1;
                        cntD  = 4'(expIn - 5'd25);
                    end
                end
            end

            SHIFT: begin
                if (cntQ != 4'd0) begin
                    if (leftQ) begin
                        sigD = {sigQ[14:0], 1'b0};
                    end else begin
                        sigD    = {1'b0, sigQ[15:1]};
                        stickyD = stickyQ | sigQ[0];
                    end
                    cntD = cntQ - 4'd1;
                end else begin
                    stateD = DONE;
                    if (specialQ || (magExt > limit)) begin
                        // NaN ignores its sign and saturates positive.
                        outIntD     = (signQ && !nanQ) ? MOST_NEG : MOST_POS;
                        outInvalidD = 1'b1;
                        outInexactD = 1'b0;
                    end else begin
                        outIntD     = signQ ? negMag[INT_W-1:0] : magExt[INT_W-1:0];
                        outInvalidD = 1'b0;
                        outInexactD = stickyQ;
                    end
                end
            end

            DONE: begin
                if (out_ready) begin
                    stateD = IDLE;
                end
            end

            default: begin
                stateD = IDLE;
            end
        endcase
    end

    // State register; reset drops any in-flight operand.
    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ      <= IDLE;
            sigQ        <= 16'd0;
            cntQ        <= 4'd0;
            leftQ       <= 1'b0;
            stickyQ     <= 1'b0;
            signQ       <= 1'b0;
            specialQ    <= 1'b0;
            nanQ        <= 1'b0;
            outIntQ     <= '0;
            outInvalidQ <= 1'b0;
            outInexactQ <= 1'b0;
        end else begin
            stateQ      <= stateD;
            sigQ        <= sigD;
            cntQ        <= cntD;
            leftQ       <= leftD;
            stickyQ     <= stickyD;
            signQ       <= signD;
            specialQ    <= specialD;
            nanQ        <= nanD;
            outIntQ     <= outIntD;
            outInvalidQ <= outInvalidD;
            outInexactQ <= outInexactD;
        end
    end

endmodule

// File: tb/tb_fpu_fp16_to_int.sv
// ---------------------------------------------------------------------------
// TbFpuFp16ToInt : self-checking bench for fpu_fp16_to_int (INT_W = 16).
// Expected results come from an arithmetic model of FP16 truncation and are
// queued at accept time, then popped when the converter raises out_valid.
// ---------------------------------------------------------------------------
module tb_fpu_fp16_to_int;

    localparam int INT_W = 16;

    typedef struct {
        logic [INT_W-1:0] val;
        logic             inv;
        logic             inx;
        int               lat;
    } exp_t;

    logic             clock;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_fp;
    logic             out_valid;
    logic             out_ready;
    logic [INT_W-1:0] out_int;
    logic             out_invalid;
    logic             out_inexact;

    exp_t sb[$];
    int   assertCount = 0;
    int   failCount   = 0;

    fpu_fp16_to_int #(.INT_W(INT_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_fp       (in_fp),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_int     (out_int),
        .out_invalid (out_invalid),
        .out_inexact (out_inexact)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Value = 1.frac * 2^(exp-15) = (1024+frac) * 2^(exp-25), truncated.
    function automatic exp_t model(input logic [15:0] fp);
        exp_t   r;
        longint mag;
        longint sig;
        longint lim;
        int     e;
        bit     inx;
        bit     spec;
        bit     nan;
        logic       s;
        logic [4:0] ex;
        logic [9:0] fr;
        s = fp[15];
        ex = fp[14:10];
        fr = fp[9:0];
        mag = 0;
        inx = 0;
        spec = 0;
        nan = 0;
        r.lat = 2;
        if (ex == 5'd31) begin
            spec = 1;
            nan = (fr != 0);
        end else if (ex == 5'd0) begin
            inx = (fr != 0);
        end else begin
            sig = 1024 + longint'(fr);
            e = int'(ex) - 25;
            if (e >= 0) begin
                mag = sig << e;
            end else begin
                mag = sig >> (-e);
                inx = ((sig & ((64'sd1 << (-e)) - 1)) != 0);
            end
            if (ex >= 5'd15) r.lat = 2 + ((e < 0) ? -e : e);
        end
        lim = s ? (64'sd1 <<< (INT_W-1)) : ((64'sd1 <<< (INT_W-1)) - 1);
        if (spec || mag > lim) begin
            r.val = (s && !nan) ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
            r.inv = 1'b1;
            r.inx = 1'b0;
        end else begin
            r.val = INT_W'(s ? -mag : mag);
            r.inv = 1'b0;
            r.inx = inx;
        end
        return r;
    endfunction

    // Drive one operand, queue its expected result, wait for out_valid and
    // hand back the popped expectation and the measured latency.
    task automatic applyStimulus(input logic [15:0] fp, output exp_t e,
                                 output int lat, output bit timedOut);
        int guard;
        guard = 0;
        timedOut = 1'b0;
        @(negedge clock);
        in_fp = fp;
        in_valid = 1'b1;
        while (!in_ready && guard < 40) begin
            @(negedge clock);
            guard++;
        end
        if (!in_ready) timedOut = 1'b1;
        sb.push_back(model(fp));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        if (!out_valid) timedOut = 1'b1;
        e = sb.pop_front();
    endtask

    // Output handshake: one cycle of out_ready.
    task automatic checkOutput();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
        assertCount++;
        if (out_valid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        assertCount++;
        if (out_int !== '0) begin failCount++; $display("[TB] FAIL reset_out_int got %h want 0", out_int); end
        assertCount++;
        if ({out_invalid, out_inexact} !== 2'b00) begin
            failCount++; $display("[TB] FAIL reset_flags got %b%b want 00", out_invalid, out_inexact);
        end
    endtask

    // Runs a table of operands and checks value, flags and latency of each.
    task automatic test_table(input string tag, input logic [15:0] vec[]);
        exp_t e;
        int   lat;
        bit   to;
        foreach (vec[i]) begin
            applyStimulus(vec[i], e, lat, to);
            assertCount++;
            if (to) begin failCount++; $display("[TB] FAIL %s_timeout in=%h got no out_valid want out_valid", tag, vec[i]); end
            assertCount++;
            if (out_int !== e.val) begin failCount++; $display("[TB] FAIL %s_int in=%h got %h want %h", tag, vec[i], out_int, e.val); end
            assertCount++;
            if ({out_invalid, out_inexact} !== {e.inv, e.inx}) begin
                failCount++;
                $display("[TB] FAIL %s_flags in=%h got inv=%b inx=%b want inv=%b inx=%b",
                         tag, vec[i], out_invalid, out_inexact, e.inv, e.inx);
            end
            assertCount++;
            if (lat != e.lat) begin failCount++; $display("[TB] FAIL %s_latency in=%h got %0d want %0d", tag, vec[i], lat, e.lat); end
            checkOutput();
        end
    endtask

    task automatic test_basic();
        logic [15:0] v[] = '{16'h3C00, 16'hC100};
        test_table("basic", v);
    endtask

    task automatic test_boundaries();
        logic [15:0] v[] = '{16'hF800, 16'h7800, 16'h7BFF, 16'h6800, 16'hE800};
        test_table("bound", v);
    endtask

    task automatic test_specials();
        logic [15:0] v[] = '{16'h7C00, 16'hFC00, 16'h7E00, 16'hFE00,
                             16'h0001, 16'h8000, 16'h3800, 16'h0000};
        test_table("special", v);
    endtask

    task automatic test_random();
        logic [15:0] v[];
        v = new[24];
        foreach (v[i]) v[i] = 16'($urandom_range(0, 65535));
        test_table("random", v);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat;
        bit   to;
        applyStimulus(16'h4500, e, lat, to);
        assertCount++;
        if (to || out_int !== e.val) begin
            failCount++; $display("[TB] FAIL bp_first got %h (timeout=%0d) want %h", out_int, to, e.val);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            assertCount++;
            if ({out_valid, in_ready, out_int} !== {1'b1, 1'b0, e.val}) begin
                failCount++;
                $display("[TB] FAIL bp_hold cycle %0d got v=%b r=%b int=%h want v=1 r=0 int=%h",
                         c, out_valid, in_ready, out_int, e.val);
            end
        end
        checkOutput();
        assertCount++;
        if ({out_valid, in_ready} !== 2'b01) begin
            failCount++; $display("[TB] FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready);
        end
        applyStimulus(16'h4900, e, lat, to);
        assertCount++;
        if (to || out_int !== e.val || {out_invalid, out_inexact} !== 2'b00) begin
            failCount++;
            $display("[TB] FAIL b2b_second got %h inv=%b inx=%b (timeout=%0d) want %h flags 00",
                     out_int, out_invalid, out_inexact, to, e.val);
        end
        checkOutput();
    endtask

    task automatic test_reset_mid_shift();
        exp_t e;
        int   lat;
        bit   to;
        bit   sawValid;
        sawValid = 1'b0;
        @(negedge clock);
        in_fp = 16'h3C00;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        if (out_valid) sawValid = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        assertCount++;
        if (in_ready !== 1'b1) begin failCount++; $display("[TB] FAIL rst_mid_in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 15; c++) begin
            @(posedge clock);
            #1;
            if (out_valid) sawValid = 1'b1;
        end
        assertCount++;
        if (sawValid) begin failCount++; $display("[TB] FAIL rst_mid_dropped got out_valid=1 want 0"); end
        applyStimulus(16'h4000, e, lat, to);
        assertCount++;
        if (to || out_int !== e.val || out_invalid !== 1'b0) begin
            failCount++; $display("[TB] FAIL rst_mid_after got %h inv=%b (timeout=%0d) want %h inv=0",
                                  out_int, out_invalid, to, e.val);
        end
        checkOutput();
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_fp = 16'h0000;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundaries();
        test_specials();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        assertCount++;
        if (sb.size() != 0) begin failCount++; $display("[TB] FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
